// File: rtl/vga_scan_engine.sv
`default_nettype none
// ============================================================================
// Module  : vga_scan_engine
// Purpose : VGA raster engine. Counts the raster, issues linear frame-buffer
//           read addresses for 2^SCALE_SHIFT integer pixel scaling, realigns
//           sync/blank flags with the colour returned MEM_LATENCY cycles
//           later, and drives a 10-bit-per-channel DAC.
// Ports   : vga_clock, resetn (async, active-low)
//           pixel_colour   {R,G,B} from video memory, BPC bits each
//           memory_address linear dot address (valid with mem_rd_en)
//           mem_rd_en      current raster position is in the active region
//           VGA_R/G/B      DAC colour, zero outside active video
//           VGA_HS/VGA_VS  syncs, active level set by HS_POL/VS_POL
//           VGA_BLANK      1 = active video; VGA_SYNC constant 1
//           VGA_CLK        pixel clock to the DAC
//           frame_start    pulse aligned with output pixel (0,0)
//           vblank         output line is in vertical blanking
// Revision: 1.0  initial release
// ============================================================================
module vga_scan_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int SCALE_SHIFT = 1,
  parameter int BPC         = 1,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 17
) (
  input  logic                vga_clock,
  input  logic                resetn,
  input  logic [3*BPC-1:0]    pixel_colour,
  output logic [ADDR_W-1:0]   memory_address,
  output logic                mem_rd_en,
  output logic [9:0]          VGA_R,
  output logic [9:0]          VGA_G,
  output logic [9:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK,
  output logic                VGA_SYNC,
  output logic                VGA_CLK,
  output logic                frame_start,
  output logic                vblank
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam int c_DLY     = MEM_LATENCY + 1;
  localparam int c_SUB     = 1 << SCALE_SHIFT;
  localparam int c_DOTS    = H_ACTIVE >> SCALE_SHIFT;
  localparam int c_ROWS    = V_ACTIVE >> SCALE_SHIFT;
  localparam longint c_DOT_COUNT = longint'(c_DOTS) * longint'(c_ROWS);

  localparam logic [c_HW-1:0]   c_H_LAST    = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0]   c_V_LAST    = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_HW-1:0]   c_H_ACT     = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0]   c_H_ACT_M1  = c_HW'(H_ACTIVE - 1);
  localparam logic [c_VW-1:0]   c_V_ACT     = c_VW'(V_ACTIVE);
  localparam logic [c_HW-1:0]   c_HS_BEG    = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0]   c_HS_END    = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [c_VW-1:0]   c_VS_BEG    = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0]   c_VS_END    = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [c_HW-1:0]   c_SUB_MSK_H = c_HW'(c_SUB - 1);
  localparam logic [c_VW-1:0]   c_SUB_MSK_V = c_VW'(c_SUB - 1);
  localparam logic [ADDR_W-1:0] c_DOTS_A    = ADDR_W'(c_DOTS);
  localparam logic              c_HS_ON     = 1'(HS_POL);
  localparam logic              c_VS_ON     = 1'(VS_POL);

  // Parameter sanity: reject configurations the address generator cannot serve.
  generate
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_err_scale_range
      $error("vga_scan_engine: SCALE_SHIFT must be 0..3");
    end
    if ((H_ACTIVE % c_SUB) != 0 || (V_ACTIVE % c_SUB) != 0) begin : g_err_scale_div
      $error("vga_scan_engine: H_ACTIVE/V_ACTIVE not divisible by 2^SCALE_SHIFT");
    end
    if (c_DOT_COUNT > (64'd1 << ADDR_W)) begin : g_err_addr_w
      $error("vga_scan_engine: ADDR_W too small for frame buffer");
    end
    if (BPC < 1 || BPC > 10) begin : g_err_bpc
      $error("vga_scan_engine: BPC must be 1..10");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_err_latency
      $error("vga_scan_engine: MEM_LATENCY must be 1..4");
    end
  endgenerate

  // ---------------------------------------------------------------- raster
  logic [c_HW-1:0] r_h;
  logic [c_VW-1:0] r_v;
  logic            w_h_last, w_v_last, w_h_act, w_v_act, w_active;

  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);
  assign w_h_act  = (r_h < c_H_ACT);
  assign w_v_act  = (r_v < c_V_ACT);
  assign w_active = w_h_act & w_v_act;

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // --------------------------------------------------------------- address
  // r_addr always holds the address of the current raster position (or the
  // last active one). It is updated for the position about to be entered, so
  // no multiplier is needed: the dot advances at the end of each 2^S group and
  // the line base steps by one dot row every 2^S lines.
  logic [ADDR_W-1:0] r_addr, r_line_base, w_line_base_nxt;
  logic [c_VW-1:0]   w_v_next;
  logic              w_sub_end, w_v_next_act, w_v_next_row;

  assign w_v_next        = r_v + 1'b1;
  assign w_sub_end       = ((r_h & c_SUB_MSK_H) == c_SUB_MSK_H);
  assign w_v_next_act    = (w_v_next < c_V_ACT);
  assign w_v_next_row    = ((w_v_next & c_SUB_MSK_V) == '0);
  assign w_line_base_nxt = w_v_next_row ? r_line_base + c_DOTS_A : r_line_base;

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_line_base <= '0;
    end else if (w_h_last) begin
      if (w_v_last) begin
        r_addr      <= '0;
        r_line_base <= '0;
      end else if (w_v_next_act) begin
        r_addr      <= w_line_base_nxt;
        r_line_base <= w_line_base_nxt;
      end
    end else if (w_v_act && (r_h < c_H_ACT_M1) && w_sub_end) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign memory_address = r_addr;
  // Gated with resetn so the strobe is low while held in reset even though the
  // raster already sits at the active position (0,0).
  assign mem_rd_en      = w_active & resetn;

  // ------------------------------------------------------- timing pipeline
  logic w_hs, w_vs, w_fs;
  logic [c_DLY-1:0] r_hs_d, r_vs_d, r_blank_d, r_vbl_d, r_fs_d;

  assign w_hs = (r_h >= c_HS_BEG) && (r_h <= c_HS_END);
  assign w_vs = (r_v >= c_VS_BEG) && (r_v <= c_VS_END);
  assign w_fs = (r_h == '0) && (r_v == '0);

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      r_hs_d    <= '0;
      r_vs_d    <= '0;
      r_blank_d <= '0;
      r_vbl_d   <= '0;
      r_fs_d    <= '0;
    end else begin
      r_hs_d    <= {r_hs_d[c_DLY-2:0], w_hs};
      r_vs_d    <= {r_vs_d[c_DLY-2:0], w_vs};
      r_blank_d <= {r_blank_d[c_DLY-2:0], w_active};
      r_vbl_d   <= {r_vbl_d[c_DLY-2:0], ~w_v_act};
      r_fs_d    <= {r_fs_d[c_DLY-2:0], w_fs};
    end
  end

  assign VGA_HS      = r_hs_d[c_DLY-1] ? c_HS_ON : ~c_HS_ON;
  assign VGA_VS      = r_vs_d[c_DLY-1] ? c_VS_ON : ~c_VS_ON;
  assign VGA_BLANK   = r_blank_d[c_DLY-1];
  assign vblank      = r_vbl_d[c_DLY-1];
  assign frame_start = r_fs_d[c_DLY-1];
  assign VGA_SYNC    = 1'b1;
  assign VGA_CLK     = vga_clock;

  // ----------------------------------------------------------------- colour
  // Each channel is widened by repeating its bits MSB-first, so full scale
  // maps to 10'h3FF and zero to zero.
  logic [BPC-1:0] w_r_in, w_g_in, w_b_in;
  logic [9:0]     w_r_exp, w_g_exp, w_b_exp;
  logic           w_pix_on;

  assign w_r_in = pixel_colour[3*BPC-1 -: BPC];
  assign w_g_in = pixel_colour[2*BPC-1 -: BPC];
  assign w_b_in = pixel_colour[BPC-1:0];

  generate
    for (genvar i = 0; i < 10; i++) begin : g_expand
      assign w_r_exp[9-i] = w_r_in[BPC-1-(i % BPC)];
      assign w_g_exp[9-i] = w_g_in[BPC-1-(i % BPC)];
      assign w_b_exp[9-i] = w_b_in[BPC-1-(i % BPC)];
    end
  endgenerate

  // pixel_colour now belongs to the pixel whose blank flag sits one stage
  // short of the output; registering here lands colour with VGA_BLANK.
  assign w_pix_on = r_blank_d[c_DLY-2];

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= w_pix_on ? w_r_exp : '0;
      VGA_G <= w_pix_on ? w_g_exp : '0;
      VGA_B <= w_pix_on ? w_b_exp : '0;
    end
  end

endmodule
`default_nettype wire
